// File: rtl/pong_io_pkg.sv
// pong_io_pkg
// Shared definitions for the pong board I/O blocks:
//   - rep_state_e : per-channel auto-repeat FSM states
//   - cnt_width() : counter width able to hold the value n (never 0 bits)
//   - max_u()     : larger of two unsigned values, for sizing shared counters
//   - *_100MHZ    : default timing constants for the 100 MHz board clock
package pong_io_pkg;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_100MHZ = 32'd1_000_000;  // 10 ms
    localparam int unsigned REPEAT_DELAY_100MHZ    = 32'd50_000_000; // 500 ms
    localparam int unsigned REPEAT_PERIOD_100MHZ   = 32'd10_000_000; // 100 ms

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel
// One button input path: two-flop synchroniser, counter debouncer, rise/fall
// pulse generation and (with AUTOREPEAT_EN defined) an auto-repeat FSM that
// turns a held button into a periodic press stream.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   btn_i        raw asynchronous button level (1 = pressed)
//   level_o      debounced level
//   press_o      one-cycle pulse on debounced rise or repeat tick
//   release_o    one-cycle pulse on debounced fall
//   press_next_o value press_o will take at the next edge, so the parent can
//                register a derived output that stays aligned with press_o
//
// Build option: AUTOREPEAT_EN (undefined: no repeat logic is generated).
module button_channel
    import pong_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_o
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rise, fall;

`ifdef AUTOREPEAT_EN
    localparam int unsigned   RW         = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

    rep_state_e    rstate_q;
    logic [RW-1:0] rcnt_q;
    logic          rep_fire;
`endif

    // Synchroniser
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    // Debounce next-state and pulse generation
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise      = level_d & ~level_q;
        fall      = ~level_d & level_q;
        release_d = fall;
`ifdef AUTOREPEAT_EN
        // A falling level wins over a due repeat tick in the same cycle.
        rep_fire = 1'b0;
        if (!fall) begin
            case (rstate_q)
                R_DELAY:  rep_fire = (rcnt_q == DELAY_LAST);
                R_REPEAT: rep_fire = (rcnt_q == PER_LAST);
                default:  rep_fire = 1'b0;
            endcase
        end
        press_d = rise | rep_fire;
`else
        press_d = rise;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef AUTOREPEAT_EN
    // Auto-repeat FSM; its pulse output is registered through press_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
        end else if (fall) begin
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    rcnt_q <= '0;
                    if (rise) rstate_q <= R_DELAY;
                end
                R_DELAY: begin
                    if (rcnt_q == DELAY_LAST) begin
                        rstate_q <= R_REPEAT;
                        rcnt_q   <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                R_REPEAT: begin
                    if (rcnt_q == PER_LAST) rcnt_q <= '0;
                    else                    rcnt_q <= rcnt_q + RW'(1);
                end
                default: begin
                    rstate_q <= R_IDLE;
                    rcnt_q   <= '0;
                end
            endcase
        end
    end
`endif

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/pmod_button_conditioner.sv
// pmod_button_conditioner
// Multi-channel conditioner for the PMOD breadboard buttons. Each channel is
// synchronised, debounced and edge-detected independently by button_channel;
// this level replicates the channel and produces the polarity-adjusted,
// registered pulse output.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   btn_in_i   [CHANNELS] raw button levels (1 = pressed)
//   level_o    [CHANNELS] debounced levels
//   press_o    [CHANNELS] one-cycle press pulses (incl. repeat ticks)
//   release_o  [CHANNELS] one-cycle release pulses
//   out_o      [CHANNELS] press_o with OUT_ACTIVE_LOW polarity, registered
//
// Build option: AUTOREPEAT_EN enables per-channel auto-repeat.
module pmod_button_conditioner
    import pong_io_pkg::*;
#(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter bit          OUT_ACTIVE_LOW  = 1'b1,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] btn_in_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] out_o
);

    // XOR with this mask applies the polarity; it is also the idle/reset value.
    localparam logic [CHANNELS-1:0] OUT_IDLE = OUT_ACTIVE_LOW ? '1 : '0;

    logic [CHANNELS-1:0] press_next;
    logic [CHANNELS-1:0] out_q, out_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .btn_i        (btn_in_i[g]),
            .level_o      (level_o[g]),
            .press_o      (press_o[g]),
            .release_o    (release_o[g]),
            .press_next_o (press_next[g])
        );
    end

    always_comb begin
        out_d = press_next ^ OUT_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) out_q <= OUT_IDLE;
        else       out_q <= out_d;
    end

    assign out_o = out_q;

endmodule

// File: tb/tb_pmod_button_conditioner.sv
module tb_pmod_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] level, press, rel, out;

    int checks = 0;
    int errors = 0;

    pmod_button_conditioner #(
        .CHANNELS        (2),
        .DEBOUNCE_CYCLES (4),
        .OUT_ACTIVE_LOW  (1'b1),
        .REPEAT_DELAY    (6),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_in_i  (btn),
        .level_o   (level),
        .press_o   (press),
        .release_o (rel),
        .out_o     (out)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    initial begin
        logic [5:0] pat;
        logic [1:0] exp_p;
        bit         autorep;
`ifdef AUTOREPEAT_EN
        autorep = 1'b1;
`else
        autorep = 1'b0;
`endif

        // Reset with both buttons held
        rst = 1'b1;
        btn = 2'b11;
        step(2);
        chk("rst_level", level, 2'b00);
        chk("rst_press", press, 2'b00);
        chk("rst_release", rel, 2'b00);
        chk("rst_out", out, 2'b11);
        rst = 1'b0;
        step(5);
        chk("held_early", press, 2'b00);
        step(1);
        chk("held_press", press, 2'b11);
        chk("held_out", out, 2'b00);
        chk("held_level", level, 2'b11);
        step(1);
        chk("held_press_end", press, 2'b00);
        chk("held_out_end", out, 2'b11);
        btn = 2'b00;
        step(5);
        chk("held_rel_early", rel, 2'b00);
        step(1);
        chk("held_release", rel, 2'b11);
        chk("held_rel_level", level, 2'b00);
        step(1);
        chk("held_rel_end", rel, 2'b00);

        // Clean press on ch0
        btn = 2'b01;
        step(5);
        chk("clean_early", press, 2'b00);
        chk("clean_lvl_early", level, 2'b00);
        step(1);
        chk("clean_level", level, 2'b01);
        chk("clean_press", press, 2'b01);
        chk("clean_out", out, 2'b10);
        step(1);
        chk("clean_press_end", press, 2'b00);
        chk("clean_out_end", out, 2'b11);
        btn = 2'b00;
        step(5);
        chk("clean_rel_early", rel, 2'b00);
        step(1);
        chk("clean_release", rel, 2'b01);
        chk("clean_rel_level", level, 2'b00);
        step(1);
        chk("clean_rel_end", rel, 2'b00);

        // Bounce on ch1: 1,1,0,1,1,0 then 0
        pat = 6'b011011;
        for (int i = 0; i < 6; i++) begin
            btn = {pat[i], 1'b0};
            step(1);
            chk("bounce_level", level, 2'b00);
            chk("bounce_events", press | rel, 2'b00);
        end
        btn = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("bounce_tail_level", level, 2'b00);
            chk("bounce_tail_events", press | rel, 2'b00);
        end

        // Simultaneous press, then ch0 released two cycles later
        btn = 2'b11;
        step(5);
        chk("sim_early", press, 2'b00);
        step(1);
        chk("sim_press", press, 2'b11);
        chk("sim_out", out, 2'b00);
        step(2);
        btn = 2'b10;
        step(5);
        chk("sim_rel_early", rel, 2'b00);
        chk("sim_rel_lvl_early", level, 2'b11);
        step(1);
        chk("sim_release0", rel, 2'b01);
        chk("sim_level_after", level, 2'b10);
        step(1);
        chk("sim_rel_end", rel, 2'b00);
        btn = 2'b00;
        step(6);
        chk("sim_release1", rel, 2'b10);
        chk("sim_level_idle", level, 2'b00);
        step(1);

        // Reset mid-debounce on ch0
        btn = 2'b01;
        step(4);
        rst = 1'b1;
        step(1);
        chk("mid_rst_level", level, 2'b00);
        chk("mid_rst_press", press, 2'b00);
        chk("mid_rst_out", out, 2'b11);
        rst = 1'b0;
        step(5);
        chk("mid_rst_early", press, 2'b00);
        chk("mid_rst_lvl_early", level, 2'b00);
        step(1);
        chk("mid_rst_pulse", press, 2'b01);
        chk("mid_rst_out_pulse", out, 2'b10);
        step(1);
        btn = 2'b00;
        step(7);
        chk("mid_rst_idle", level, 2'b00);

        // Long hold on ch0: repeat stream with AUTOREPEAT_EN, single press otherwise
        btn = 2'b01;
        step(6);
        chk("hold_first", press, 2'b01);
        for (int k = 1; k <= 24; k++) begin
            step(1);
            exp_p = (autorep && k >= 6 && k < 24 && ((k - 6) % 3) == 0) ? 2'b01 : 2'b00;
            chk("hold_press", press, exp_p);
            chk("hold_out", out, ~exp_p);
            if (k == 18) btn = 2'b00;
            if (k == 24) chk("hold_release", rel, 2'b01);
        end
        step(1);
        chk("hold_rel_end", rel, 2'b00);
        chk("hold_level_end", level, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmod_button_conditioner.md
# pmod_button_conditioner

Parametrised, multi-channel input conditioner for the pong game's PMOD breadboard buttons, and next generation of the two-button PMOD input block. Each channel gets a two-flop synchroniser, a counter-based debouncer and rise/fall edge detection. The block emits one-cycle press/release pulses plus a polarity-selectable pulse output for the paddle and game logic. An optional auto-repeat mode turns a held button into a periodic press stream.

## Interface
- CHANNELS, 2, number of independent button channels (>=1)
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from the debounced level before the level flips (>=1; 10 ms at 100 MHz)
- OUT_ACTIVE_LOW, 1, 1: `out` idles high and pulses low; 0: idles low and pulses high
- REPEAT_DELAY, 50000000, cycles from press to first auto-repeat pulse (>=1; used only with AUTOREPEAT_EN)
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (>=1; used only with AUTOREPEAT_EN)
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- btn_in  input  CHANNELS  raw asynchronous button levels from the PMOD header (1 = pressed)
- level  output  CHANNELS  debounced button level
- press  output  CHANNELS  one-cycle pulse per debounced rising edge (and per auto-repeat tick)
- release  output  CHANNELS  one-cycle pulse per debounced falling edge
- out  output  CHANNELS  `press` with OUT_ACTIVE_LOW polarity applied, registered

## Operation
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Synchroniser: `btn_in` -> s1 -> s2. Only s2 feeds the debouncer.
- Debouncer, per channel: counter `cnt` of width $clog2(DEBOUNCE_CYCLES+1).
  - s2 == level: `cnt` <= 0.
  - s2 != level and `cnt` == DEBOUNCE_CYCLES-1: `level` <= s2 and `cnt` <= 0.
  - Otherwise: `cnt` increments.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and never reaches `level`.
- Edge pulses: `press` is high for exactly the one cycle in which `level` first reads 1. `release` is high for the one cycle in which `level` first reads 0.
- `out` = OUT_ACTIVE_LOW ? ~press : press.
- Reset values: s1, s2, `cnt`, `level`, `press`, `release` all 0; `out` all 1 if OUT_ACTIVE_LOW, else 0.
- A button held through reset is reported as a normal press once the debounce window elapses after reset release.
- Reset asserted mid-debounce or mid-repeat: all state returns to reset values immediately, with no pulse emitted.

## Timing
- Input changes and then holds from edge t: s2 reflects it at t+2; `level`, `press` and `release` update at edge t+2+DEBOUNCE_CYCLES. `out` updates in the same cycle as `press`.
- `press` and `release` never overlap on one channel. The minimum spacing between them is DEBOUNCE_CYCLES.
- No handshake; consumers must sample the pulses every cycle.

## Configuration
- AUTOREPEAT_EN defined: adds a per-channel repeat FSM with a counter of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - R_IDLE: on a debounced press, go to R_DELAY with `rcnt` = 0.
  - R_DELAY: when `rcnt` == REPEAT_DELAY-1, emit a `press` pulse, go to R_REPEAT and clear `rcnt`.
  - R_REPEAT: emit a `press` pulse every REPEAT_PERIOD cycles.
  - Any state: `level` falling returns the FSM to R_IDLE in the same cycle, and no repeat pulse fires in that cycle.
  - Reset state is R_IDLE.
- AUTOREPEAT_EN undefined: no repeat logic is generated. `press` fires once per debounced rising edge. REPEAT_* parameters are ignored.

## Structure
- Shared package `pong_io_pkg`:
  - repeat FSM state enum (R_IDLE, R_DELAY, R_REPEAT)
  - helper function for counter widths
  - default DEBOUNCE_CYCLES and REPEAT_* constants for the 100 MHz board clock
- Sub-module `button_channel` (one channel: synchroniser, debouncer, edge detect, optional repeat FSM).
- The top level instantiates CHANNELS copies in a generate loop and applies the `out` polarity.

## Test plan
Bench parameters: CHANNELS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3.
- Reset: assert rst with btn_in=2'b11 -> level=00, press=00, release=00, out=11. Release rst and hold btn_in -> press=11 for one cycle exactly 6 cycles later.
- Clean press on ch0: btn_in 00->01 at edge t and held -> level[0]=1 and press[0]=1 at t+6, out[0]=0 for that cycle only. Drop to 00 -> release[0]=1 six cycles after the drop.
- Bounce on ch1: pattern 1,1,0,1,1,0 (each value for one cycle), then 0 -> level[1] stays 0, and no press or release ever fires.
- Simultaneous: both channels rise on the same edge -> press=11 in the same cycle. Ch0 released two cycles later -> ch1 unaffected.
- Reset mid-debounce: rst pulsed at t+4 of a ch0 press -> no pulse. The pulse appears 6 cycles after rst deasserts, provided the input is still held.
- AUTOREPEAT_EN: hold ch0 for 20 cycles after its press pulse at P -> repeat pulses at P+6, P+9, P+12, ...; releasing stops them with no pulse in the release cycle. Without the macro -> exactly one press.
